fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pc_write  input  1  PC advance enable from hazard detection (0 = stall).
REQ-005 SHALL have port ifid_write  input  1  IF/ID register load enable from hazard detection (0 = stall).
REQ-006 SHALL have port flush  input  1  taken branch/jump resolved in ID; redirect fetch.
REQ-007 SHALL have port branch_target  input  32  redirect address, sampled when flush=1.
REQ-008 SHALL have port imem_req  output  1  instruction fetch request.
REQ-009 SHALL have port imem_addr  output  32  fetch address, equal to current PC.
REQ-010 SHALL have port imem_ready  input  1  fetch accepted and imem_rdata valid in the same cycle.
REQ-011 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-012 SHALL have port if_instr  output  32  IF/ID instruction (32'h0 = NOP when invalid).
REQ-013 SHALL have port if_pc4  output  32  IF/ID PC+4 of the held instruction.
REQ-014 SHALL have port if_valid  output  1  IF/ID holds a real instruction.

Function
REQ-015 SHALL implement two-state FSM: FETCH (imem_req=1) and HOLD (fetched word parked in skid buffer, imem_req=0).
REQ-016 SHALL drive imem_addr = PC combinationally, in both states.
REQ-017 SHALL define fetch-complete = FETCH && imem_ready; advance = pc_write && ifid_write; pc_write != ifid_write SHALL be treated as stall.
REQ-018 SHALL apply flush as highest priority, overriding stall and fetch-complete: PC <= branch_target, if_valid <= 0, if_instr <= 0, skid buffer discarded, state <= FETCH, any same-cycle fetched word dropped.
REQ-019 FETCH, fetch-complete, advance: if_instr <= imem_rdata, if_pc4 <= PC+4, if_valid <= 1, PC <= PC+4, stay FETCH.
REQ-020 FETCH, fetch-complete, stall: imem_rdata and PC+4 captured into skid buffer, PC held, IF/ID held, state <= HOLD.
REQ-021 FETCH, no fetch-complete, advance: IF/ID loaded with bubble (if_valid=0, if_instr=0, if_pc4 held), PC held.
REQ-022 FETCH, no fetch-complete, stall: PC and IF/ID held.
REQ-023 HOLD, advance: IF/ID loaded from skid buffer with if_valid=1, PC <= PC+4, state <= FETCH (next fetch issues following cycle).
REQ-024 HOLD, stall: all state held; imem_ready ignored.
REQ-025 SHALL compute PC+4 modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0).
REQ-026 SHALL not alter PC except via REQ-018/019/023; branch_target SHALL be used unmodified (no alignment masking).
REQ-027 Fetch-to-IF/ID latency SHALL be 1 cycle with no stall; at most one fetched word buffered.

Reset
REQ-028 rst_n=0 SHALL immediately set PC=RESET_PC, if_instr=0, if_pc4=0, if_valid=0, skid buffer invalid, state FETCH, and force imem_req=0 while rst_n=0.
REQ-029 Reset asserted mid-HOLD or mid-fetch SHALL discard all buffered data; first request after release SHALL be at RESET_PC.

Verification
REQ-030 Reset release, imem_ready=1, rdata=0x11,0x22,0x33, no stall -> imem_addr 0x0,0x4,0x8; if_instr 0x11,0x22,0x33 one cycle later, if_pc4 0x4,0x8,0xC, if_valid=1.
REQ-031 Stall (pc_write=ifid_write=0) 2 cycles while fetch of 0x8 completes with 0x33 -> imem_req drops, IF/ID held; on release if_instr=0x33, if_pc4=0xC, next imem_addr=0xC.
REQ-032 imem_ready=0 for 3 cycles, no stall -> if_valid=0, if_instr=0 for 3 cycles, imem_addr constant.
REQ-033 flush=1, branch_target=0x100, simultaneous with stall and fetch-complete -> next imem_addr=0x100, if_valid=0, fetched word never appears on if_instr.
REQ-034 PC=32'hFFFF_FFFC, fetch completes, advance -> if_pc4=0x0, next imem_addr=0x0.
REQ-035 rst_n pulsed low while in HOLD -> if_valid=0 immediately, imem_req=0 during reset, first post-reset imem_addr=RESET_PC, buffered word never emitted.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-cycle instruction
// memory requests and loads the IF/ID pipeline register. A one-entry skid
// buffer parks a word that arrives while the pipeline is stalled.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   FETCH | request outstanding at PC (imem_req=1)
//   HOLD  | fetched word parked in skid buffer, waiting for advance
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        ifid_write,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        if_valid
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc4;
  logic        r_if_valid;
  // The skid buffer holds a word exactly when the FSM is in HOLD.
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc4;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_if_instr_nxt;
  logic [31:0] w_if_pc4_nxt;
  logic        w_if_valid_nxt;
  logic [31:0] w_skid_instr_nxt;
  logic [31:0] w_skid_pc4_nxt;

  logic        w_fetch_done;
  logic        w_advance;
  logic [31:0] w_pc_plus4;

  // A mismatched pair of write enables counts as a stall.
  assign w_fetch_done = (r_state == FETCH) && imem_ready;
  assign w_advance    = pc_write && ifid_write;
  assign w_pc_plus4   = r_pc + 32'd4;

  assign imem_req  = (r_state == FETCH) && rst_n;
  assign imem_addr = r_pc;
  assign if_instr  = r_if_instr;
  assign if_pc4    = r_if_pc4;
  assign if_valid  = r_if_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decisions; flush outranks stall and fetch data.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_if_instr_nxt   = r_if_instr;
    w_if_pc4_nxt     = r_if_pc4;
    w_if_valid_nxt   = r_if_valid;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc4_nxt   = r_skid_pc4;
    if (flush) begin
      w_pc_nxt       = branch_target;
      w_if_instr_nxt = 32'h0;
      w_if_valid_nxt = 1'b0;
      w_state_nxt    = FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_fetch_done) begin
            if (w_advance) begin
              w_if_instr_nxt = imem_rdata;
              w_if_pc4_nxt   = w_pc_plus4;
              w_if_valid_nxt = 1'b1;
              w_pc_nxt       = w_pc_plus4;
            end else begin
              w_skid_instr_nxt = imem_rdata;
              w_skid_pc4_nxt   = w_pc_plus4;
              w_state_nxt      = HOLD;
            end
          end else if (w_advance) begin
            // Nothing arrived: push a bubble, keep if_pc4 as it was.
            w_if_instr_nxt = 32'h0;
            w_if_valid_nxt = 1'b0;
          end
        end
        HOLD: begin
          if (w_advance) begin
            w_if_instr_nxt = r_skid_instr;
            w_if_pc4_nxt   = r_skid_pc4;
            w_if_valid_nxt = 1'b1;
            w_pc_nxt       = w_pc_plus4;
            w_state_nxt    = FETCH;
          end
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  // PC, IF/ID and skid buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_if_instr   <= 32'h0;
      r_if_pc4     <= 32'h0;
      r_if_valid   <= 1'b0;
      r_skid_instr <= 32'h0;
      r_skid_pc4   <= 32'h0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_if_instr   <= w_if_instr_nxt;
      r_if_pc4     <= w_if_pc4_nxt;
      r_if_valid   <= w_if_valid_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc4   <= w_skid_pc4_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table walks the stage through
// streaming, stalls, bubbles, flushes and PC wrap; a hand-written sequence
// covers asynchronous reset while a word is parked in the skid buffer.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        pc_write;
  logic        ifid_write;
  logic        flush;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_valid;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .if_instr      (if_instr),
    .if_pc4        (if_pc4),
    .if_valid      (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for one cycle, the request expected before the edge, and the
  // IF/ID contents expected after it.
  typedef struct {
    logic        pw;
    logic        iw;
    logic        fl;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic pw, logic iw, logic fl, logic [31:0] tgt,
                              logic rdy, logic [31:0] rd, logic e_req,
                              logic [31:0] e_addr, logic e_valid,
                              logic [31:0] e_instr, logic [31:0] e_pc4);
    vec_t v;
    v.pw = pw; v.iw = iw; v.fl = fl; v.tgt = tgt; v.rdy = rdy; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc4 = e_pc4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pw, input logic iw, input logic fl,
                       input logic [31:0] tgt, input logic rdy, input logic [31:0] rd);
    pc_write      = pw;
    ifid_write    = iw;
    flush         = fl;
    branch_target = tgt;
    imem_ready    = rdy;
    imem_rdata    = rd;
  endtask

  task automatic apply(input int idx, input vec_t v);
    string tag;
    @(negedge clk);
    drive(v.pw, v.iw, v.fl, v.tgt, v.rdy, v.rd);
    #1;
    tag = $sformatf("v%0d", idx);
    chk({tag, "_req"},  {31'b0, imem_req}, {31'b0, v.e_req});
    chk({tag, "_addr"}, imem_addr, v.e_addr);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, {31'b0, if_valid}, {31'b0, v.e_valid});
    chk({tag, "_instr"}, if_instr, v.e_instr);
    chk({tag, "_pc4"},   if_pc4, v.e_pc4);
  endtask

  initial begin
    //               pw  iw  fl  target        rdy rdata         req addr          vld instr         pc4
    // streaming from reset
    vecs[0]  = mk(1, 1, 0, 32'h0,         1, 32'h11,        1, 32'h0,         1, 32'h11,        32'h4);
    vecs[1]  = mk(1, 1, 0, 32'h0,         1, 32'h22,        1, 32'h4,         1, 32'h22,        32'h8);
    // two-cycle stall while fetch of 0x8 completes; second stall cycle in HOLD
    vecs[2]  = mk(0, 0, 0, 32'h0,         1, 32'h33,        1, 32'h8,         1, 32'h22,        32'h8);
    vecs[3]  = mk(0, 0, 0, 32'h0,         1, 32'hDEAD,      0, 32'h8,         1, 32'h22,        32'h8);
    vecs[4]  = mk(1, 1, 0, 32'h0,         1, 32'hBEEF,      0, 32'h8,         1, 32'h33,        32'hC);
    // memory not ready for three cycles: bubbles, address steady
    vecs[5]  = mk(1, 1, 0, 32'h0,         0, 32'hAAAA,      1, 32'hC,         0, 32'h0,         32'hC);
    vecs[6]  = mk(1, 1, 0, 32'h0,         0, 32'hAAAA,      1, 32'hC,         0, 32'h0,         32'hC);
    vecs[7]  = mk(1, 1, 0, 32'h0,         0, 32'hAAAA,      1, 32'hC,         0, 32'h0,         32'hC);
    vecs[8]  = mk(1, 1, 0, 32'h0,         1, 32'h44,        1, 32'hC,         1, 32'h44,        32'h10);
    // flush together with stall and fetch-complete: fetched 0x55 dropped
    vecs[9]  = mk(0, 0, 1, 32'h100,       1, 32'h55,        1, 32'h10,        0, 32'h0,         32'h10);
    vecs[10] = mk(1, 1, 0, 32'h0,         1, 32'h66,        1, 32'h100,       1, 32'h66,        32'h104);
    // mismatched enables park 0x77, then a flush from HOLD discards it
    vecs[11] = mk(1, 0, 0, 32'h0,         1, 32'h77,        1, 32'h104,       1, 32'h66,        32'h104);
    vecs[12] = mk(1, 1, 1, 32'h200,       1, 32'h0,         0, 32'h104,       0, 32'h0,         32'h104);
    vecs[13] = mk(1, 1, 0, 32'h0,         1, 32'h88,        1, 32'h200,       1, 32'h88,        32'h204);
    // PC wrap at the top of the address space
    vecs[14] = mk(1, 1, 1, 32'hFFFF_FFFC, 1, 32'h99,        1, 32'h204,       0, 32'h0,         32'h204);
    vecs[15] = mk(1, 1, 0, 32'h0,         1, 32'hAA,        1, 32'hFFFF_FFFC, 1, 32'hAA,        32'h0);
    vecs[16] = mk(1, 1, 0, 32'h0,         1, 32'hBB,        1, 32'h0,         1, 32'hBB,        32'h4);
    // HOLD ignores imem_ready and the other mismatched-enable combination
    vecs[17] = mk(0, 0, 0, 32'h0,         1, 32'hCC,        1, 32'h4,         1, 32'hBB,        32'h4);
    vecs[18] = mk(0, 0, 0, 32'h0,         1, 32'hDD,        0, 32'h4,         1, 32'hBB,        32'h4);
    vecs[19] = mk(0, 1, 0, 32'h0,         1, 32'hDD,        0, 32'h4,         1, 32'hBB,        32'h4);
    vecs[20] = mk(1, 1, 0, 32'h0,         1, 32'hDD,        0, 32'h4,         1, 32'hCC,        32'h8);
    vecs[21] = mk(1, 1, 0, 32'h0,         1, 32'hEE,        1, 32'h8,         1, 32'hEE,        32'hC);
    // unaligned branch target is used as-is
    vecs[22] = mk(1, 1, 1, 32'h123,       0, 32'h0,         1, 32'hC,         0, 32'h0,         32'hC);
    vecs[23] = mk(1, 1, 0, 32'h0,         1, 32'h1234_5678, 1, 32'h123,       1, 32'h1234_5678, 32'h127);

    drive(0, 0, 0, 32'h0, 0, 32'h0);
    rst_n = 1'b0;
    #3;
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc4",   if_pc4, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) apply(i, vecs[i]);

    // Park 0xFF in the skid buffer, then reset asynchronously mid-cycle.
    apply(100, mk(0, 0, 0, 32'h0, 1, 32'hFF, 1, 32'h127, 1, 32'h1234_5678, 32'h127));
    #2;
    rst_n = 1'b0;
    #1;
    chk("hrst_valid", {31'b0, if_valid}, 32'h0);
    chk("hrst_instr", if_instr, 32'h0);
    chk("hrst_pc4",   if_pc4, 32'h0);
    chk("hrst_req",   {31'b0, imem_req}, 32'h0);
    chk("hrst_addr",  imem_addr, 32'h0);
    drive(1, 1, 0, 32'h0, 1, 32'hFF);
    @(posedge clk);
    #1;
    chk("hrst_req_held",   {31'b0, imem_req}, 32'h0);
    chk("hrst_valid_held", {31'b0, if_valid}, 32'h0);
    @(negedge clk);
    drive(1, 1, 0, 32'h0, 1, 32'h5A);
    rst_n = 1'b1;
    #1;
    chk("post_req",  {31'b0, imem_req}, 32'h1);
    chk("post_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    chk("post_valid", {31'b0, if_valid}, 32'h1);
    chk("post_instr", if_instr, 32'h5A);
    chk("post_pc4",   if_pc4, 32'h4);
    @(negedge clk);
    #1;
    chk("post_addr2", imem_addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
